// File: rtl/link_stack_if.sv
// Call/return handshake between the execute stage and the link stack.
// The master presents calls and returns; the slave is the stack, which owns LR and the redirect/stall outputs.
interface link_stack_if #(
   parameter int DEPTH = 8
);
   localparam int DW = $clog2(DEPTH) + 1;

   logic          call_i;
   logic [15:0]   call_pc_i;
   logic          link_back_i;
   logic          clear_flags_i;
   logic [15:0]   lr_o;
   logic          redirect_o;
   logic [15:0]   redirect_addr_o;
   logic          stall_o;
   logic [DW-1:0] depth_o;
   logic          overflow_o;
   logic          underflow_o;

   modport master (
      output call_i, call_pc_i, link_back_i, clear_flags_i,
      input  lr_o, redirect_o, redirect_addr_o, stall_o, depth_o, overflow_o, underflow_o
   );

   modport slave (
      input  call_i, call_pc_i, link_back_i, clear_flags_i,
      output lr_o, redirect_o, redirect_addr_o, stall_o, depth_o, overflow_o, underflow_o
   );
endinterface

// File: rtl/link_stack.sv
// Return-address stack with a live link register, a one-cycle fetch redirect on return,
// and a fixed flush stall. A full stack drops its oldest entry; an empty pop yields 0xFFFF.
module link_stack #(
   parameter int DEPTH        = 8,
   parameter int FLUSH_CYCLES = 2,
   parameter int PC_STEP      = 2
) (
   input logic          clk,
   input logic          rst,
   link_stack_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int DW = AW + 1;
   localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_REDIR = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;

   logic [15:0]   mem [DEPTH];
   logic [AW-1:0] sp;
   logic [AW-1:0] sp_dec;
   logic [DW-1:0] depth;
   logic [15:0]   lr;
   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic          redirect;
   logic [15:0]   redirect_addr;
   logic          stall;
   logic          overflow;
   logic          underflow;
   logic          idle;
   logic          pop;
   logic          push;
   logic          full;
   logic          empty;

   always_comb begin
      idle   = (state == ST_IDLE);
      pop    = idle & bus.link_back_i;
      push   = idle & bus.call_i & ~bus.link_back_i;
      full   = (depth == DW'(DEPTH));
      empty  = (depth == {DW{1'b0}});
      sp_dec = sp - AW'(1);
   end

   // Array has no reset: its contents are meaningless until pushed.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[sp] <= lr;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_IDLE;
         sp            <= {AW{1'b0}};
         depth         <= {DW{1'b0}};
         lr            <= 16'h0000;
         cnt           <= {CW{1'b0}};
         redirect      <= 1'b0;
         redirect_addr <= 16'h0000;
         stall         <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pop) begin
                  state         <= ST_REDIR;
                  redirect      <= 1'b1;
                  stall         <= 1'b1;
                  redirect_addr <= lr;
                  if (!empty) begin
                     lr    <= mem[sp_dec];
                     sp    <= sp_dec;
                     depth <= depth - DW'(1);
                  end else begin
                     lr <= 16'hFFFF;
                  end
               end else if (push) begin
                  sp <= sp + AW'(1);
                  lr <= bus.call_pc_i + 16'(PC_STEP);
                  if (!full) begin
                     depth <= depth + DW'(1);
                  end
               end
            end
            ST_REDIR: begin
               redirect <= 1'b0;
               if (FLUSH_CYCLES == 0) begin
                  state <= ST_IDLE;
                  stall <= 1'b0;
               end else begin
                  state <= ST_FLUSH;
                  cnt   <= CW'(FLUSH_CYCLES - 1);
               end
            end
            ST_FLUSH: begin
               if (cnt == {CW{1'b0}}) begin
                  state <= ST_IDLE;
                  stall <= 1'b0;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            default: begin
               state    <= ST_IDLE;
               redirect <= 1'b0;
               stall    <= 1'b0;
            end
         endcase
      end
   end

   // A new overflow/underflow event in the clearing cycle keeps the flag set.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= (push & full)  | (overflow  & ~bus.clear_flags_i);
         underflow <= (pop  & empty) | (underflow & ~bus.clear_flags_i);
      end
   end

   assign bus.lr_o            = lr;
   assign bus.redirect_o      = redirect;
   assign bus.redirect_addr_o = redirect_addr;
   assign bus.stall_o         = stall;
   assign bus.depth_o         = depth;
   assign bus.overflow_o      = overflow;
   assign bus.underflow_o     = underflow;
endmodule

// File: tb/tb_link_stack.sv
// Bench for link_stack: directed scenarios plus random traffic, every output compared each
// cycle against a queue-based stack model with a stall-window counter.
module tb_link_stack;
   localparam int DEPTH = 8;
   localparam int FLUSH = 2;
   localparam int STEP  = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   link_stack_if #(.DEPTH(DEPTH)) bus ();

   link_stack #(.DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH), .PC_STEP(STEP)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [15:0] m_stk [$];
   logic [15:0] m_lr;
   logic [15:0] m_raddr;
   int          m_busy;
   bit          m_redir;
   bit          m_ovf;
   bit          m_unf;

   int pass_cnt = 0;
   int fail_cnt = 0;
   int total    = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_stk.delete();
      m_lr    = 16'h0000;
      m_raddr = 16'h0000;
      m_busy  = 0;
      m_redir = 1'b0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
   endtask

   task automatic model_edge();
      bit ov;
      bit un;
      ov = 1'b0;
      un = 1'b0;
      if (rst) begin
         model_reset();
      end else begin
         m_redir = 1'b0;
         if (m_busy == 0) begin
            if (bus.link_back_i) begin
               m_raddr = m_lr;
               m_redir = 1'b1;
               m_busy  = 1 + FLUSH;
               if (m_stk.size() > 0) begin
                  m_lr = m_stk.pop_back();
               end else begin
                  m_lr = 16'hFFFF;
                  un   = 1'b1;
               end
            end else if (bus.call_i) begin
               if (m_stk.size() == DEPTH) begin
                  void'(m_stk.pop_front());
                  ov = 1'b1;
               end
               m_stk.push_back(m_lr);
               m_lr = 16'((32'(bus.call_pc_i) + STEP) % 65536);
            end
         end else begin
            m_busy--;
         end
         m_ovf = ov | (m_ovf & !bus.clear_flags_i);
         m_unf = un | (m_unf & !bus.clear_flags_i);
      end
   endtask

   task automatic check_all();
      chk("lr",       32'(bus.lr_o),            32'(m_lr));
      chk("depth",    32'(bus.depth_o),         32'(m_stk.size()));
      chk("stall",    32'(bus.stall_o),         32'(m_busy > 0));
      chk("redirect", 32'(bus.redirect_o),      32'(m_redir));
      chk("raddr",    32'(bus.redirect_addr_o), 32'(m_raddr));
      chk("ovf",      32'(bus.overflow_o),      32'(m_ovf));
      chk("unf",      32'(bus.underflow_o),     32'(m_unf));
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic drive(input bit c, input logic [15:0] pc, input bit lb, input bit clr);
      bus.call_i        = c;
      bus.call_pc_i     = pc;
      bus.link_back_i   = lb;
      bus.clear_flags_i = clr;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(1'b0, 16'h0000, 1'b0, 1'b0);
      cycle();
      rst = 1'b0;
   endtask

   initial begin
      int n;
      model_reset();
      do_reset();
      repeat (5) cycle();
      chk("reset_lr",    32'(bus.lr_o),    32'h0000);
      chk("reset_depth", 32'(bus.depth_o), 32'd0);
      chk("reset_stall", 32'(bus.stall_o), 32'd0);

      // Two calls then a return; stall window length measured directly.
      drive(1'b1, 16'h0100, 1'b0, 1'b0); cycle();
      drive(1'b1, 16'h0200, 1'b0, 1'b0); cycle();
      chk("lr_before_ret",    32'(bus.lr_o),    32'h0202);
      chk("depth_before_ret", 32'(bus.depth_o), 32'd2);
      drive(1'b0, 16'h0000, 1'b1, 1'b0); cycle();
      chk("ret_raddr", 32'(bus.redirect_addr_o), 32'h0202);
      chk("ret_redir", 32'(bus.redirect_o),      32'd1);
      chk("ret_lr",    32'(bus.lr_o),            32'h0102);
      chk("ret_depth", 32'(bus.depth_o),         32'd1);
      drive(1'b0, 16'h0000, 1'b0, 1'b0);
      n = 1;
      for (int i = 0; i < 10; i++) begin
         cycle();
         if (bus.stall_o) n++;
         else break;
      end
      chk("stall_len", 32'(n), 32'd3);

      // Overflow by nine calls, then nine returns down to underflow.
      do_reset();
      for (int i = 1; i <= 9; i++) begin
         drive(1'b1, 16'(i * 16), 1'b0, 1'b0); cycle();
      end
      chk("ovf_after_9", 32'(bus.overflow_o), 32'd1);
      for (int i = 0; i < 9; i++) begin
         drive(1'b0, 16'h0000, 1'b1, 1'b0); cycle();
         chk("pop_raddr", 32'(bus.redirect_addr_o), 32'(16'h0092 - 16'(i * 16)));
         drive(1'b0, 16'h0000, 1'b0, 1'b0);
         repeat (FLUSH + 1) cycle();
      end
      chk("underflow_lr",  32'(bus.lr_o),        32'hFFFF);
      chk("underflow_flg", 32'(bus.underflow_o), 32'd1);

      // PC wrap, then simultaneous call and return.
      drive(1'b1, 16'hFFFE, 1'b0, 1'b1); cycle();
      chk("wrap_lr", 32'(bus.lr_o), 32'h0000);
      drive(1'b1, 16'h1234, 1'b1, 1'b0); cycle();
      chk("simul_redir", 32'(bus.redirect_o), 32'd1);
      chk("simul_lr",    32'(bus.lr_o),       32'hFFFF);
      drive(1'b0, 16'h0000, 1'b0, 1'b0);
      repeat (FLUSH + 1) cycle();

      // Requests presented during REDIR and FLUSH are dropped.
      drive(1'b1, 16'h0300, 1'b0, 1'b0); cycle();
      drive(1'b1, 16'h0400, 1'b0, 1'b0); cycle();
      drive(1'b0, 16'h0000, 1'b1, 1'b0); cycle();
      drive(1'b1, 16'h0500, 1'b0, 1'b0); cycle();
      drive(1'b0, 16'h0000, 1'b1, 1'b0); cycle();
      drive(1'b0, 16'h0000, 1'b0, 1'b0); cycle();
      chk("ignored_lr",    32'(bus.lr_o),    32'h0302);
      chk("ignored_stall", 32'(bus.stall_o), 32'd0);
      cycle();

      // Reset in the second flush cycle aborts the sequence.
      drive(1'b0, 16'h0000, 1'b1, 1'b0); cycle();
      drive(1'b0, 16'h0000, 1'b0, 1'b0); cycle(); cycle();
      rst = 1'b1; cycle(); rst = 1'b0;
      chk("abort_stall", 32'(bus.stall_o), 32'd0);
      chk("abort_depth", 32'(bus.depth_o), 32'd0);
      chk("abort_lr",    32'(bus.lr_o),    32'h0000);

      // Overflow in the same cycle as a clear keeps the flag.
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b1, 16'(i * 4), 1'b0, 1'b0); cycle();
      end
      drive(1'b1, 16'h0AA0, 1'b0, 1'b1); cycle();
      chk("clr_vs_set", 32'(bus.overflow_o), 32'd1);
      drive(1'b0, 16'h0000, 1'b0, 1'b1); cycle();
      chk("clr_only", 32'(bus.overflow_o), 32'd0);

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         drive(($urandom_range(0, 1) == 1), 16'($urandom()),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0));
         rst = ($urandom_range(0, 99) == 0);
         cycle();
      end
      rst = 1'b0;

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule

// File: doc/link_stack.md
# link_stack

Return-address stack and link-register owner for the XM23 pipeline. It is the call side of the subroutine-link mechanism. A BL at execute pushes the live link value and loads the new return address. A link-back request from the return detector (LD from sentinel address 0xFFFF at execute) pops the stack and drives a one-cycle fetch redirect, followed by a fixed flush stall. It sits beside the execute stage and feeds the fetch PC mux and the hazard/stall logic.

## Interface
Parameters:
- DEPTH, 8: stack entries behind the live LR; power of two, ≥2.
- FLUSH_CYCLES, 2: stall cycles after the redirect cycle; 0 is legal.
- PC_STEP, 2: return address = call PC + PC_STEP.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- call_i  in  1  BL instruction valid in execute stage.
- call_pc_i  in  16  PC of that BL.
- link_back_i  in  1  return request from the link-back detector.
- clear_flags_i  in  1  clears sticky overflow/underflow.
- lr_o  out  16  current link register value.
- redirect_o  out  1  one-cycle fetch redirect strobe.
- redirect_addr_o  out  16  redirect target, valid while redirect_o=1.
- stall_o  out  1  holds fetch/decode during redirect and flush.
- depth_o  out  $clog2(DEPTH)+1  number of valid stacked entries.
- overflow_o  out  1  sticky: push while full.
- underflow_o  out  1  sticky: pop while empty.

## Operation
- Storage: DEPTH×16 circular array, write pointer sp, count depth. lr_o is a separate register (top of stack).
- FSM states:
  - IDLE: accepts call_i and link_back_i.
  - REDIR: redirect_o=1, stall_o=1; lasts 1 cycle.
  - FLUSH: stall_o=1; down-counter from FLUSH_CYCLES-1 to 0, then IDLE.
  - With FLUSH_CYCLES=0, REDIR goes directly to IDLE.
- Call in IDLE (call_i=1, link_back_i=0):
  - mem[sp] ← lr_o; sp ← sp+1 mod DEPTH.
  - depth ← min(depth+1, DEPTH).
  - lr_o ← call_pc_i + PC_STEP, truncated to 16 bits (0xFFFE+2 → 0x0000).
- Push when depth==DEPTH:
  - Oldest entry is overwritten (pointer wraps); depth stays DEPTH; overflow_o ← 1.
- Link-back in IDLE:
  - redirect_addr_o ← lr_o; state ← REDIR.
  - If depth>0: lr_o ← mem[sp-1]; sp ← sp-1; depth ← depth-1.
  - If depth==0: lr_o ← 16'hFFFF, pointer unchanged, underflow_o ← 1.
- Simultaneous call_i and link_back_i: link-back wins and the call is dropped.
- call_i/link_back_i outside IDLE are ignored. Stalled stages cannot legitimately present them.
- clear_flags_i clears both sticky flags next edge. If a new overflow/underflow event occurs in the same cycle, set wins.
- No combinational path from any input to any output; all outputs are registered.

## Timing
- Reset values:
  - lr_o=16'h0000, redirect_o=0, redirect_addr_o=16'h0000, stall_o=0.
  - depth_o=0, overflow_o=0, underflow_o=0, sp=0, state=IDLE.
  - Array contents are don't-care.
- rst during REDIR/FLUSH aborts the sequence; all outputs take reset values the following cycle.
- Call accepted at edge N: lr_o and depth_o new values visible after edge N (cycle N+1).
- Link-back sampled at edge N:
  - Cycle N+1: redirect_o=1, stall_o=1, redirect_addr_o=old lr_o; lr_o and depth_o already hold the popped values.
  - Cycles N+2 … N+1+FLUSH_CYCLES: stall_o=1, redirect_o=0.
  - Cycle N+2+FLUSH_CYCLES: IDLE, stall_o=0; new requests accepted that cycle.
- Back-to-back calls: one push per cycle, no bubbles.
- redirect_addr_o holds its value after redirect_o falls, until the next link-back.

## Test plan
- Reset, then idle 5 cycles → lr_o=0x0000, depth_o=0, stall_o=0, redirect_o=0, flags 0.
- call_pc 0x0100 then 0x0200 on consecutive cycles, then link_back → lr_o=0x0202, depth_o=2 before return. Cycle after link_back: redirect_addr_o=0x0202, redirect_o=1, lr_o=0x0102, depth_o=1. stall_o high for exactly 3 cycles (FLUSH_CYCLES=2).
- 9 calls (DEPTH=8, PCs 0x0010…0x0090 step 0x10) then 9 link_backs → overflow_o=1 after the 9th call. Redirect addresses are 0x0092, 0x0082, …, 0x0012, with reset LR 0x0000 lost. The 9th pop returns 0x0012 and sets lr_o to 0xFFFF with underflow_o=1.
- call_pc 0xFFFE → lr_o=0x0000 (wrap). Simultaneous call_i+link_back_i → only redirect occurs; depth_o decrements; the call's PC is never loaded.
- link_back during FLUSH, and call_i during REDIR → both ignored; depth_o and lr_o unchanged; stall window length unchanged.
- rst asserted in second FLUSH cycle → next cycle stall_o=0, depth_o=0, lr_o=0. clear_flags_i with a simultaneous overflow push → overflow_o stays 1.
